// File: rtl/apple_spawn_ctrl_pkg.sv
// Shared constants and types for the apple re-spawn controller.
//   GRID_W/GRID_H : playfield size in cells (640x480 pixels / CELL)
//   CELL          : pixels per cell edge
//   START_CX/CY   : apple cell after reset
//   state_e       : spawn FSM states
//   fold_cell()   : folds a 6-bit random value into 1..span (border ring excluded)
package apple_spawn_ctrl_pkg;

  localparam int unsigned GRID_W    = 64;
  localparam int unsigned GRID_H    = 48;
  localparam int unsigned CELL      = 10;
  localparam int unsigned START_CX  = 32;
  localparam int unsigned START_CY  = 24;
  localparam int unsigned MAX_TRIES = 16;
  localparam int unsigned SALT_STEP = 37;
  localparam int unsigned CELL_W    = 6;

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StQuery,
    StScanStep,
    StCommit,
    StGiveup
  } state_e;

  // A single conditional subtract is enough because 2*span >= 64.
  function automatic logic [CELL_W-1:0] fold_cell(input logic [CELL_W-1:0] v,
                                                  input logic [CELL_W-1:0] span);
    logic [CELL_W-1:0] folded;
    folded = (v >= span) ? (v - span) : v;
    return folded + CELL_W'(1);
  endfunction

endpackage

// File: rtl/apple_spawn_ctrl_if.sv
// Occupancy query handshake between the spawn controller and the snake-body checker.
//   occ_req        : query valid, held until occ_ack
//   occ_cx/occ_cy  : queried cell, stable while occ_req is high
//   occ_ack        : query answered (may be combinational on occ_req)
//   occ_hit        : qualified by occ_ack, 1 = cell occupied
// master = spawn controller, slave = occupancy checker.
interface apple_spawn_ctrl_if;
  import apple_spawn_ctrl_pkg::*;

  logic              occ_req;
  logic [CELL_W-1:0] occ_cx;
  logic [CELL_W-1:0] occ_cy;
  logic              occ_ack;
  logic              occ_hit;

  modport master (
    output occ_req,
    output occ_cx,
    output occ_cy,
    input  occ_ack,
    input  occ_hit
  );

  modport slave (
    input  occ_req,
    input  occ_cx,
    input  occ_cy,
    output occ_ack,
    output occ_hit
  );

endinterface

// File: rtl/apple_spawn_ctrl_cand_gen.sv
// Combinational candidate-cell generator.
//   i_rnd[11:0] : low LFSR bits (cx from [5:0], cy from [11:6])
//   i_salt      : per-draw salt, xored in to decorrelate consecutive draws
//   o_cx/o_cy   : candidate cell, 1..GRID_W-2 / 1..GRID_H-2
module apple_spawn_ctrl_cand_gen #(
  parameter int unsigned GRID_W = apple_spawn_ctrl_pkg::GRID_W,
  parameter int unsigned GRID_H = apple_spawn_ctrl_pkg::GRID_H
) (
  input  logic [11:0]                             i_rnd,
  input  logic [7:0]                              i_salt,
  output logic [apple_spawn_ctrl_pkg::CELL_W-1:0] o_cx,
  output logic [apple_spawn_ctrl_pkg::CELL_W-1:0] o_cy
);
  import apple_spawn_ctrl_pkg::*;

  localparam logic [CELL_W-1:0] SpanX = CELL_W'(GRID_W - 2);
  localparam logic [CELL_W-1:0] SpanY = CELL_W'(GRID_H - 2);

  logic [CELL_W-1:0] w_vx;
  logic [CELL_W-1:0] w_vy;

  assign w_vx = i_rnd[5:0] ^ i_salt[5:0];
  assign w_vy = i_rnd[11:6] ^ i_salt[7:2];

  assign o_cx = fold_cell(w_vx, SpanX);
  assign o_cy = fold_cell(w_vy, SpanY);

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple re-spawn sequencer. On an eat event it draws salted random cells, asks the
// occupancy checker about each, and commits the first free one. After MAX_TRIES
// occupied draws it raster-scans from the last drawn cell; a full lap of hits gives up.
//   clk_pix, reset_n     : pixel clock, async active-low reset
//   eat_evt, moved_once  : spawn trigger (only honoured in idle after the first move)
//   rnd                  : free-running LFSR value
//   occ_if (master)      : occupancy query handshake
//   apple_x, apple_y     : committed apple top-left in pixels
//   busy                 : controller not idle
//   spawn_done/grid_full : 1-cycle result pulses
module apple_spawn_ctrl #(
  parameter int unsigned GRID_W    = apple_spawn_ctrl_pkg::GRID_W,
  parameter int unsigned GRID_H    = apple_spawn_ctrl_pkg::GRID_H,
  parameter int unsigned CELL      = apple_spawn_ctrl_pkg::CELL,
  parameter int unsigned MAX_TRIES = apple_spawn_ctrl_pkg::MAX_TRIES,
  parameter int unsigned SALT_STEP = apple_spawn_ctrl_pkg::SALT_STEP
) (
  input  logic                      clk_pix,
  input  logic                      reset_n,
  input  logic                      eat_evt,
  input  logic                      moved_once,
  input  logic [15:0]               rnd,
  apple_spawn_ctrl_if.master        occ_if,
  output logic [9:0]                apple_x,
  output logic [8:0]                apple_y,
  output logic                      busy,
  output logic                      spawn_done,
  output logic                      grid_full
);
  import apple_spawn_ctrl_pkg::*;

  localparam int unsigned NumCells = (GRID_W - 2) * (GRID_H - 2);
  localparam int unsigned ScanW    = $clog2(NumCells + 1);
  localparam int unsigned TriesW   = $clog2(MAX_TRIES + 1);

  localparam logic [CELL_W-1:0] CxMax    = CELL_W'(GRID_W - 2);
  localparam logic [CELL_W-1:0] CyMax    = CELL_W'(GRID_H - 2);
  localparam logic [9:0]        CellX    = 10'(CELL);
  localparam logic [8:0]        CellY    = 9'(CELL);
  localparam logic [9:0]        ResetX   = 10'(START_CX * CELL);
  localparam logic [8:0]        ResetY   = 9'(START_CY * CELL);
  localparam logic [7:0]        SaltInc  = 8'(SALT_STEP);
  localparam logic [TriesW-1:0] TriesMax = TriesW'(MAX_TRIES);
  localparam logic [ScanW-1:0]  ScanLast = ScanW'(NumCells);

  state_e            r_state;
  logic [TriesW-1:0] r_tries;
  logic [7:0]        r_salt;
  logic [ScanW-1:0]  r_scan_cnt;
  logic              r_scan_mode;
  logic [CELL_W-1:0] r_cx;
  logic [CELL_W-1:0] r_cy;
  logic              r_occ_req;
  logic [9:0]        r_apple_x;
  logic [8:0]        r_apple_y;
  logic              r_busy;
  logic              r_spawn_done;
  logic              r_grid_full;

  logic [CELL_W-1:0] w_cand_cx;
  logic [CELL_W-1:0] w_cand_cy;
  logic              w_unused_rnd;

  assign w_unused_rnd = ^rnd[15:12];

  apple_spawn_ctrl_cand_gen #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_cand_gen (
    .i_rnd  (rnd[11:0]),
    .i_salt (r_salt),
    .o_cx   (w_cand_cx),
    .o_cy   (w_cand_cy)
  );

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_tries      <= '0;
      r_salt       <= '0;
      r_scan_cnt   <= '0;
      r_scan_mode  <= 1'b0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_occ_req    <= 1'b0;
      r_apple_x    <= ResetX;
      r_apple_y    <= ResetY;
      r_busy       <= 1'b0;
      r_spawn_done <= 1'b0;
      r_grid_full  <= 1'b0;
    end else begin
      r_spawn_done <= 1'b0;
      r_grid_full  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (eat_evt && moved_once) begin
            r_tries <= '0;
            r_busy  <= 1'b1;
            r_state <= StDraw;
          end
        end
        StDraw: begin
          r_cx        <= w_cand_cx;
          r_cy        <= w_cand_cy;
          r_salt      <= r_salt + SaltInc;
          r_tries     <= r_tries + TriesW'(1);
          r_scan_mode <= 1'b0;
          r_occ_req   <= 1'b1;
          r_state     <= StQuery;
        end
        StQuery: begin
          if (occ_if.occ_ack) begin
            r_occ_req <= 1'b0;
            if (!occ_if.occ_hit) begin
              // Outputs and done pulse become visible together in the COMMIT cycle.
              r_apple_x    <= 10'(r_cx) * CellX;
              r_apple_y    <= 9'(r_cy) * CellY;
              r_spawn_done <= 1'b1;
              r_state      <= StCommit;
            end else if (r_scan_mode) begin
              if (r_scan_cnt == ScanLast) begin
                r_grid_full <= 1'b1;
                r_state     <= StGiveup;
              end else begin
                r_state <= StScanStep;
              end
            end else if (r_tries < TriesMax) begin
              r_state <= StDraw;
            end else begin
              // The last random cell counts as the first cell of the scan lap.
              r_scan_cnt  <= ScanW'(1);
              r_scan_mode <= 1'b1;
              r_state     <= StScanStep;
            end
          end
        end
        StScanStep: begin
          if (r_cx >= CxMax) begin
            r_cx <= CELL_W'(1);
            r_cy <= (r_cy >= CyMax) ? CELL_W'(1) : r_cy + CELL_W'(1);
          end else begin
            r_cx <= r_cx + CELL_W'(1);
          end
          r_scan_cnt <= r_scan_cnt + ScanW'(1);
          r_occ_req  <= 1'b1;
          r_state    <= StQuery;
        end
        StCommit, StGiveup: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy    <= 1'b0;
          r_occ_req <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign occ_if.occ_req = r_occ_req;
  assign occ_if.occ_cx  = r_cx;
  assign occ_if.occ_cy  = r_cy;
  assign apple_x        = r_apple_x;
  assign apple_y        = r_apple_y;
  assign busy           = r_busy;
  assign spawn_done     = r_spawn_done;
  assign grid_full      = r_grid_full;

endmodule
